// File: rtl/asa_wb_stage_if.sv
// EX/LSU-to-WB handshake bundle plus the registered register-file write port.
// Latency: none, wires only.
// Backpressure: wb_ready_o is driven by the slave and ex_valid_i is held by the master until accepted.
interface asa_wb_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  ex_valid_i;
    logic                  wb_ready_o;
    logic [XLEN-1:0]       ex_result_i;
    logic                  regfile_wr_en_i;
    logic [REG_ADDR_W-1:0] regfile_wr_addr_i;
    logic                  is_load_i;
    logic [2:0]            load_type_i;
    logic                  lsu_rvalid_i;
    logic [XLEN-1:0]       lsu_rdata_i;
    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_waddr_o;
    logic [XLEN-1:0]       rf_wdata_o;
    logic                  wb_busy_o;

    modport slave (
        input  ex_valid_i, ex_result_i, regfile_wr_en_i, regfile_wr_addr_i,
               is_load_i, load_type_i, lsu_rvalid_i, lsu_rdata_i,
        output wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_busy_o
    );

    modport master (
        output ex_valid_i, ex_result_i, regfile_wr_en_i, regfile_wr_addr_i,
               is_load_i, load_type_i, lsu_rvalid_i, lsu_rdata_i,
        input  wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_busy_o
    );
endinterface

// File: rtl/asa_wb_stage.sv
// Write-back stage: retires ALU results and aligned/extended load data onto one registered RF write port.
// Latency: 1 cycle for ALU ops; loads write 1 cycle after lsu_rvalid_i.
// Backpressure: wb_ready_o drops while a load waits for LSU data; EX must hold its instruction.
module asa_wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    asa_wb_stage_if.slave     bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LSU = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic                  ld_we_q, ld_we_d;
    logic [2:0]            ld_type_q, ld_type_d;
    logic [1:0]            ld_off_q, ld_off_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

    logic                  accept;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [XLEN-1:0]       load_data;

    assign bus.wb_ready_o = (state_q == IDLE);
    assign bus.wb_busy_o  = (state_q == WAIT_LSU);
    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_wdata_o = rf_wdata_q;

    assign accept = bus.ex_valid_i && bus.wb_ready_o;

    // Halfword select ignores addr[0]: misaligned halfwords never reach this stage.
    assign byte_sel = bus.lsu_rdata_i[{ld_off_q, 3'b000} +: 8];
    assign half_sel = bus.lsu_rdata_i[{ld_off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = bus.lsu_rdata_i;
        case (ld_type_q)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = bus.lsu_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld_rd_d    = ld_rd_q;
        ld_we_d    = ld_we_q;
        ld_type_d  = ld_type_q;
        ld_off_d   = ld_off_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.is_load_i) begin
                        ld_rd_d   = bus.regfile_wr_addr_i;
                        ld_we_d   = bus.regfile_wr_en_i && (bus.regfile_wr_addr_i != '0);
                        ld_type_d = bus.load_type_i;
                        ld_off_d  = bus.ex_result_i[1:0];
                        state_d   = WAIT_LSU;
                    end else if (bus.regfile_wr_en_i && (bus.regfile_wr_addr_i != '0)) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = bus.regfile_wr_addr_i;
                        rf_wdata_d = bus.ex_result_i;
                    end
                end
            end
            WAIT_LSU: begin
                // New EX requests are deliberately not looked at here, even alongside rvalid.
                if (bus.lsu_rvalid_i) begin
                    state_d = IDLE;
                    if (ld_we_q) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ld_rd_q;
                        rf_wdata_d = load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ld_rd_q    <= '0;
            ld_we_q    <= 1'b0;
            ld_type_q  <= '0;
            ld_off_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_rd_q    <= ld_rd_d;
            ld_we_q    <= ld_we_d;
            ld_type_q  <= ld_type_d;
            ld_off_q   <= ld_off_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_asa_wb_stage.sv
// Bench for asa_wb_stage: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a transaction-level model of the write-back stage.
module tb_asa_wb_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    asa_wb_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus();

    asa_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatting: shift/mask, then sign-extend by subtracting 2^n.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (t)
            3'd0, 3'd4: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (t == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (t == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Transaction-level model: one pending load at most, last written register/value.
    bit          m_busy;
    logic [4:0]  m_rd;
    bit          m_ldwe;
    logic [2:0]  m_t;
    logic [1:0]  m_a;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_rd = 0; m_ldwe = 0; m_t = 0; m_a = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            m_we = 0;
            if (m_busy) begin
                if (bus.lsu_rvalid_i) begin
                    m_busy = 0;
                    if (m_ldwe && m_rd != 0) begin
                        m_we = 1; m_waddr = m_rd; m_wdata = ref_load(m_t, m_a, bus.lsu_rdata_i);
                    end
                end
            end else if (bus.ex_valid_i) begin
                if (bus.is_load_i) begin
                    m_busy = 1; m_rd = bus.regfile_wr_addr_i; m_ldwe = bus.regfile_wr_en_i;
                    m_t = bus.load_type_i; m_a = bus.ex_result_i[1:0];
                end else if (bus.regfile_wr_en_i && bus.regfile_wr_addr_i != 0) begin
                    m_we = 1; m_waddr = bus.regfile_wr_addr_i; m_wdata = bus.ex_result_i;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_ready", 32'(bus.wb_ready_o), 32'(!m_busy));
            chk("model_busy",  32'(bus.wb_busy_o),  32'(m_busy));
            chk("model_we",    32'(bus.rf_we_o),    32'(m_we));
            chk("model_waddr", 32'(bus.rf_waddr_o), 32'(m_waddr));
            chk("model_wdata", bus.rf_wdata_o,      m_wdata);
        end
    end

    task automatic idle();
        bus.ex_valid_i   = 1'b0;
        bus.lsu_rvalid_i = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res, input logic we);
        bus.ex_valid_i        = 1'b1;
        bus.is_load_i         = 1'b0;
        bus.load_type_i       = 3'd0;
        bus.regfile_wr_addr_i = rd;
        bus.regfile_wr_en_i   = we;
        bus.ex_result_i       = res;
    endtask

    // Issue one load, hold it for 'waits' cycles (rvalid in the last), check the retirement.
    task automatic do_load(input string name, input logic [2:0] t, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                           input logic exp_we, input logic [31:0] exp_data);
        bus.ex_valid_i        = 1'b1;
        bus.is_load_i         = 1'b1;
        bus.load_type_i       = t;
        bus.ex_result_i       = addr;
        bus.regfile_wr_addr_i = rd;
        bus.regfile_wr_en_i   = 1'b1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk({name, "_ready_low"}, 32'(bus.wb_ready_o), 32'd0);
            chk({name, "_busy"},      32'(bus.wb_busy_o),  32'd1);
            chk({name, "_no_we"},     32'(bus.rf_we_o),    32'd0);
            // A competing ALU op sits on EX during the wait and must be ignored.
            drive_alu(5'd9, 32'hBAD0_BAD0, 1'b1);
            bus.lsu_rvalid_i = (i == waits - 1);
            bus.lsu_rdata_i  = (i == waits - 1) ? rdata : $urandom;
        end
        @(negedge clk);
        chk({name, "_we"},    32'(bus.rf_we_o),    32'(exp_we));
        chk({name, "_ready"}, 32'(bus.wb_ready_o), 32'd1);
        if (exp_we) begin
            chk({name, "_waddr"}, 32'(bus.rf_waddr_o), 32'(rd));
            chk({name, "_wdata"}, bus.rf_wdata_o,      exp_data);
        end
        idle();
        @(negedge clk);
        chk({name, "_pulse_end"}, 32'(bus.rf_we_o), 32'd0);
    endtask

    bit prev_rdy;

    initial begin
        bus.ex_valid_i = 0; bus.ex_result_i = 0; bus.regfile_wr_en_i = 0;
        bus.regfile_wr_addr_i = 0; bus.is_load_i = 0; bus.load_type_i = 0;
        bus.lsu_rvalid_i = 0; bus.lsu_rdata_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_we",    32'(bus.rf_we_o),    32'd0);
        chk("rst_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("rst_wdata", bus.rf_wdata_o,      32'd0);
        chk("rst_busy",  32'(bus.wb_busy_o),  32'd0);
        chk("rst_ready", 32'(bus.wb_ready_o), 32'd1);
        rst_n = 1'b1;

        drive_alu(5'd5, 32'h1234_5678, 1'b1);
        @(negedge clk);
        chk("alu_we",    32'(bus.rf_we_o),    32'd1);
        chk("alu_waddr", 32'(bus.rf_waddr_o), 32'd5);
        chk("alu_wdata", bus.rf_wdata_o,      32'h1234_5678);
        idle();
        @(negedge clk);
        chk("alu_pulse_end", 32'(bus.rf_we_o), 32'd0);
        chk("alu_hold_data", bus.rf_wdata_o,   32'h1234_5678);

        for (int r = 1; r <= 3; r++) begin
            drive_alu(5'(r), 32'hA000_0000 + r, 1'b1);
            @(negedge clk);
            chk("b2b_ready", 32'(bus.wb_ready_o), 32'd1);
            chk("b2b_we",    32'(bus.rf_we_o),    32'd1);
            chk("b2b_waddr", 32'(bus.rf_waddr_o), 32'(r));
            chk("b2b_wdata", bus.rf_wdata_o,      32'hA000_0000 + r);
        end
        idle();
        @(negedge clk);
        chk("b2b_end", 32'(bus.rf_we_o), 32'd0);

        do_load("lb",    3'd0, 32'h0000_1003, 5'd7,  32'h80FF_0000, 4, 1'b1, 32'hFFFF_FF80);
        do_load("lbu",   3'd4, 32'h0000_1003, 5'd7,  32'h80FF_0000, 4, 1'b1, 32'h0000_0080);
        do_load("lb1",   3'd0, 32'h0000_1001, 5'd6,  32'h0000_7F00, 1, 1'b1, 32'h0000_007F);
        do_load("lh",    3'd1, 32'h0000_2002, 5'd8,  32'h8001_1234, 2, 1'b1, 32'hFFFF_8001);
        do_load("lhu",   3'd5, 32'h0000_2001, 5'd8,  32'h8001_1234, 2, 1'b1, 32'h0000_1234);
        do_load("lw",    3'd2, 32'h0000_2000, 5'd11, 32'h8001_1234, 1, 1'b1, 32'h8001_1234);
        do_load("undef", 3'd6, 32'h0000_2003, 5'd12, 32'hC3C3_5A5A, 1, 1'b1, 32'hC3C3_5A5A);
        do_load("ld_x0", 3'd2, 32'h0000_2000, 5'd0,  32'hFFFF_FFFF, 2, 1'b0, 32'h0);

        drive_alu(5'd0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("x0_alu_we", 32'(bus.rf_we_o), 32'd0);
        idle();
        @(negedge clk);

        bus.lsu_rvalid_i = 1'b1;
        bus.lsu_rdata_i  = 32'h5555_5555;
        @(negedge clk);
        chk("idle_rvalid_we",    32'(bus.rf_we_o),    32'd0);
        chk("idle_rvalid_ready", 32'(bus.wb_ready_o), 32'd1);
        idle();

        bus.ex_valid_i = 1'b1; bus.is_load_i = 1'b1; bus.load_type_i = 3'd2;
        bus.regfile_wr_addr_i = 5'd10; bus.regfile_wr_en_i = 1'b1; bus.ex_result_i = 32'h100;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.wb_busy_o), 32'd1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(bus.rf_we_o),    32'd0);
        chk("mid_rst_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("mid_rst_wdata", bus.rf_wdata_o,      32'd0);
        chk("mid_rst_ready", 32'(bus.wb_ready_o), 32'd1);
        chk("mid_rst_busy0", 32'(bus.wb_busy_o),  32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.lsu_rvalid_i = 1'b1;
        bus.lsu_rdata_i  = 32'h7777_7777;
        @(negedge clk);
        chk("stray_we",    32'(bus.rf_we_o),    32'd0);
        chk("stray_ready", 32'(bus.wb_ready_o), 32'd1);
        bus.lsu_rvalid_i = 1'b0;
        drive_alu(5'd4, 32'h0000_CAFE, 1'b1);
        @(negedge clk);
        chk("post_rst_we",    32'(bus.rf_we_o),    32'd1);
        chk("post_rst_waddr", 32'(bus.rf_waddr_o), 32'd4);
        chk("post_rst_wdata", bus.rf_wdata_o,      32'h0000_CAFE);
        idle();

        prev_rdy = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if (!bus.ex_valid_i || prev_rdy) begin
                bus.ex_valid_i        = ($urandom % 4) != 0;
                bus.is_load_i         = ($urandom % 3) == 0;
                bus.load_type_i       = 3'($urandom_range(0, 7));
                bus.ex_result_i       = $urandom;
                bus.regfile_wr_addr_i = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.regfile_wr_en_i   = ($urandom % 4) != 0;
            end
            prev_rdy         = bus.wb_ready_o;
            bus.lsu_rvalid_i = ($urandom % 3) == 0;
            bus.lsu_rdata_i  = $urandom;
        end
        idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/asa_wb_stage.md
Name: asa_wb_stage

Overview:
- Write-back stage directly downstream of the EX stage.
- Accepts the EX result together with the destination register over a valid/ready handshake.
- For loads, it holds the instruction until the LSU returns read data, then aligns and sign/zero-extends that data.
- Drives one registered register-file write port, which doubles as the forwarding source for ID.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  EX presents a valid instruction.
- wb_ready_o  out  1  WB can accept an instruction this cycle.
- ex_result_i  in  XLEN  ALU/MUL/DIV result, or the effective address for loads.
- regfile_wr_en_i  in  1  instruction writes rd.
- regfile_wr_addr_i  in  REG_ADDR_W  rd.
- is_load_i  in  1  instruction is a load.
- load_type_i  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- lsu_rvalid_i  in  1  LSU read data valid (one-cycle pulse).
- lsu_rdata_i  in  XLEN  raw word-aligned read data.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  REG_ADDR_W  write address.
- rf_wdata_o  out  XLEN  write data.
- wb_busy_o  out  1  high while waiting for load data (stall to ID/EX).

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, wb_busy_o=0.
  - All captured load info cleared.
- States: IDLE, WAIT_LSU. wb_ready_o = (state==IDLE); it is combinational from the state only.
- Accept = ex_valid_i && wb_ready_o.
- Non-load accept in IDLE:
  - Next cycle: rf_we_o = regfile_wr_en_i && (regfile_wr_addr_i != 0), rf_waddr_o = rd, rf_wdata_o = ex_result_i.
  - Latency is 1 cycle; state stays IDLE.
  - Back-to-back accepts sustain 1 write per cycle.
- Load accept in IDLE:
  - Capture rd, we (forced 0 if rd==0), load_type_i, and ex_result_i[1:0]; go to WAIT_LSU.
  - rf_we_o=0 in the following cycle.
- WAIT_LSU:
  - wb_ready_o=0, wb_busy_o=1; ex_valid_i is ignored.
  - On lsu_rvalid_i: next cycle rf_we_o = captured we, rf_wdata_o = aligned data, rf_waddr_o = captured rd; state goes to IDLE.
  - wb_ready_o is asserted again in the cycle after lsu_rvalid_i, so the minimum load occupancy is 2 cycles.
- Alignment (off = captured addr[1:0]):
  - LB/LBU select byte lsu_rdata_i[8*off+7 : 8*off].
  - LH/LHU select the halfword at addr[1] (bits [15:0] or [31:16]); addr[0] is ignored because misalignment is trapped upstream.
  - LW passes the word through unchanged.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - Undefined funct3 (011, 11x) writes the raw word.
- lsu_rvalid_i in IDLE is ignored: no write and no state change.
- rf_we_o is a single-cycle pulse per instruction. It is deasserted in any cycle with no retiring instruction. rf_waddr_o and rf_wdata_o hold their last values when rf_we_o=0.
- Writes to x0 never assert rf_we_o, whatever the source (ALU or load).
- Reset asserted mid-WAIT_LSU: the pending load is dropped. A late lsu_rvalid_i after reset release is ignored because the state is IDLE.
- Simultaneous ex_valid_i and lsu_rvalid_i in WAIT_LSU: the load completes and the EX instruction is not accepted (wb_ready_o=0). EX must hold its data until wb_ready_o rises.

Test Plan:
- Non-load: after reset, send ex_valid_i=1, rd=5, result=0x1234_5678, we=1 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x12345678; following cycle rf_we_o=0.
- Back-to-back ALU ops to rd=1,2,3 on consecutive cycles -> three consecutive write pulses in order, wb_ready_o stays 1 throughout.
- Byte loads: LB at addr=...3 with rdata=0x80FF_0000, rd=7, rvalid 3 cycles later -> wb_ready_o=0 for 4 cycles, then rf_wdata_o=0xFFFF_FF80 to x7. The same access as LBU -> 0x0000_0080.
- Halfword loads: LH at addr[1]=1 with rdata=0x8001_1234 -> 0xFFFF_8001. LHU at addr[1]=0 -> 0x0000_1234. LW -> 0x8001_1234 unchanged.
- rd=0: an ALU op with rd=0 and we=1 -> rf_we_o never asserts. A load to x0 -> the state still waits for rvalid, but no write occurs.
- Reset pulse while in WAIT_LSU, followed by a stray lsu_rvalid_i -> all outputs 0, wb_ready_o=1, no write; a following ALU op retires normally.
